// File: rtl/gemm_pkg.sv
// gemm_pkg: shared state encoding and default parameters for the GEMM result writer
package gemm_pkg;
    localparam int GemmAddrWidth = 16;
    localparam int GemmDataWidth = 128;
    localparam int GemmFifoDepth = 4;
    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} gemm_state_e;
endpackage

// File: rtl/gemm_result_fifo.sv
// gemm_result_fifo: synchronous FIFO with clear and same-cycle push/pop, even when full
module gemm_result_fifo import gemm_pkg::*; #(
    parameter int Width = GemmDataWidth,
    parameter int Depth = GemmFifoDepth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PtrW = $clog2(Depth);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;
    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q[PtrW-1:0]];
    always_comb begin
        wr_d = clr_i ? '0 : wr_q + {{PtrW{1'b0}}, do_push};
        rd_d = clr_i ? '0 : rd_q + {{PtrW{1'b0}}, do_pop};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q[PtrW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/gemm_result_writer.sv
// gemm_result_writer: buffers GEMM result tiles and writes them to SRAM at consecutive C addresses
module gemm_result_writer import gemm_pkg::*; #(
    parameter int AddrWidth = GemmAddrWidth,
    parameter int DataWidth = GemmDataWidth,
    parameter int FifoDepth = GemmFifoDepth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] C_base_addr_i,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 sram_req_o,
    input  logic                 sram_gnt_i,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);
    localparam logic [AddrWidth-1:0] One = AddrWidth'(1);
    gemm_state_e          state_q, state_d;
    logic [AddrWidth-1:0] total_q, total_d, push_cnt_q, push_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d, m_tiles, n_tiles, total_new;
    logic                 error_q, error_d;
    logic                 in_run, start_go, push, pop, fifo_full, fifo_empty, last_write;
    logic [DataWidth-1:0] fifo_head;
    assign in_run     = state_q == StRun;
    assign start_go   = (state_q == StIdle) && start_i;
    assign pop        = in_run && !fifo_empty && sram_gnt_i;
    assign push       = in_run && result_valid_i && (push_cnt_q != total_q) && (!fifo_full || pop);
    assign last_write = pop && (wr_cnt_q + One == total_q);
    assign m_tiles    = ((M_size_i >> 2) == '0) ? One : (M_size_i >> 2);
    assign n_tiles    = N_size_i >> 2;
    assign total_new  = m_tiles * n_tiles;
    // A zero-tile job (Nt==0, or a product that truncates to 0) has nothing to write.
    always_comb begin
        state_d    = start_go ? (total_new == '0 ? StDone : StRun) :
                     last_write ? StDone :
                     (state_q == StDone) ? StIdle : state_q;
        total_d    = start_go ? total_new : total_q;
        push_cnt_d = start_go ? '0 : push_cnt_q + AddrWidth'(push);
        wr_cnt_d   = start_go ? '0 : wr_cnt_q + AddrWidth'(pop);
        addr_d     = start_go ? C_base_addr_i : addr_q + AddrWidth'(pop);
        error_d    = (start_go ? 1'b0 : error_q) | (result_valid_i && !push);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            total_q    <= '0;
            push_cnt_q <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            push_cnt_q <= push_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_q     <= addr_d;
            error_q    <= error_d;
        end
    end
    gemm_result_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (start_go),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (result_data_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    assign sram_req_o   = in_run && !fifo_empty;
    assign sram_wdata_o = sram_req_o ? fifo_head : '0;
    assign sram_addr_o  = addr_q;
    assign busy_o       = state_q != StIdle;
    assign done_o       = state_q == StDone;
    assign error_o      = error_q;
endmodule

// File: tb/tb_gemm_result_writer.sv
// tb_gemm_result_writer: random and directed stimulus against a queue-based reference model
module tb_gemm_result_writer;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int DEPTH = 4;
    logic          clk = 1'b0;
    logic          rst_i = 1'b0, start_i = 1'b0, result_valid_i = 1'b0, sram_gnt_i = 1'b0;
    logic [AW-1:0] M_size_i = '0, N_size_i = '0, C_base_addr_i = '0;
    logic [DW-1:0] result_data_i = '0;
    logic          sram_req_o, busy_o, done_o, error_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    always #5 clk = ~clk;
    gemm_result_writer #(.AddrWidth(AW), .DataWidth(DW), .FifoDepth(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .N_size_i       (N_size_i),
        .C_base_addr_i  (C_base_addr_i),
        .result_valid_i (result_valid_i),
        .result_data_i  (result_data_i),
        .sram_req_o     (sram_req_o),
        .sram_gnt_i     (sram_gnt_i),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );
    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Reference model: phase 0 idle, 1 run, 2 done; buffered tiles kept in a queue.
    int            phase = 0, total = 0, pushed = 0, written = 0;
    logic [AW-1:0] base = '0;
    logic          err = 1'b0;
    logic [DW-1:0] buf_q[$];
    logic [AW-1:0] gnt_addr[$];
    int            done_seen = 0, req_seen = 0;
    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic step(input logic rst, input logic st, input logic v, input logic g, input logic [DW-1:0] d);
        logic          exp_req, go, pop, push;
        logic [AW-1:0] exp_addr;
        int            mt, nt;
        rst_i = rst; start_i = st; result_valid_i = v; sram_gnt_i = g; result_data_i = d;
        exp_req  = (phase == 1) && (buf_q.size() > 0);
        exp_addr = base + AW'(written);
        check("req", sram_req_o, exp_req);
        check("addr", sram_addr_o, exp_addr);
        check("wdata", sram_wdata_o, exp_req ? buf_q[0] : '0);
        check("busy", busy_o, phase != 0);
        check("done", done_o, phase == 2);
        check("error", error_o, err);
        if (done_o) done_seen++;
        if (sram_req_o) req_seen++;
        if (sram_req_o && g) gnt_addr.push_back(sram_addr_o);
        if (rst) begin
            phase = 0; total = 0; pushed = 0; written = 0; base = '0; err = 1'b0;
            buf_q.delete();
        end else begin
            go   = (phase == 0) && st;
            pop  = (phase == 1) && (buf_q.size() > 0) && g;
            push = (phase == 1) && v && (pushed < total) && (buf_q.size() < DEPTH || pop);
            err  = (go ? 1'b0 : err) | (v && !push);
            if (pop) begin
                void'(buf_q.pop_front());
                written++;
            end
            if (push) begin
                buf_q.push_back(d);
                pushed++;
            end
            if (phase == 2) phase = 0;
            else if (pop && written == total) phase = 2;
            if (go) begin
                mt = int'(M_size_i) / 4;
                if (mt == 0) mt = 1;
                nt = int'(N_size_i) / 4;
                total = (mt * nt) % (1 << AW);
                base = C_base_addr_i; pushed = 0; written = 0;
                buf_q.delete();
                phase = (total == 0) ? 2 : 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic launch(input int m, input int n, input logic [AW-1:0] b);
        M_size_i = AW'(m); N_size_i = AW'(n); C_base_addr_i = b;
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask
    task automatic run_until_idle(input int vprob, input int gprob, input int budget);
        int k = 0;
        while (phase != 0 && k < budget) begin
            step(1'b0, 1'b0, $urandom_range(99) < vprob, $urandom_range(99) < gprob, rnd_data());
            k++;
        end
        check("job_in_budget", k < budget, 1'b1);
    endtask
    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        // 8x8 matrix: four writes at 0x100.. in order, one done pulse
        gnt_addr.delete(); done_seen = 0;
        launch(8, 8, 16'h0100);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_data());
        run_until_idle(0, 100, 20);
        check("m8n8_writes", gnt_addr.size(), 4);
        for (int i = 0; i < gnt_addr.size(); i++) check("m8n8_addr", gnt_addr[i], 16'h0100 + i);
        check("m8n8_done_pulses", done_seen, 1);
        // single-row clamp, then zero-column job
        gnt_addr.delete();
        launch(2, 4, 16'h0040);
        step(1'b0, 1'b0, 1'b1, 1'b1, rnd_data());
        run_until_idle(0, 100, 20);
        check("m2n4_writes", gnt_addr.size(), 1);
        check("m2n4_addr", gnt_addr.size() > 0 ? gnt_addr[0] : 16'hFFFF, 16'h0040);
        req_seen = 0;
        launch(4, 0, 16'h0080);
        check("n0_done_now", done_o, 1'b1);
        run_until_idle(0, 100, 5);
        check("n0_no_req", req_seen, 0);
        // overflow: six valids with no grant keep four and flag an error
        launch(16, 16, 16'h0200);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
        check("ovf_error", error_o, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        run_until_idle(60, 100, 400);
        // full FIFO with a same-cycle grant accepts the push
        launch(16, 16, 16'h0000);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
        step(1'b0, 1'b0, 1'b1, 1'b1, rnd_data());
        check("full_pop_no_error", error_o, 1'b0);
        run_until_idle(50, 50, 600);
        // reset mid-job after two writes, then a clean job
        done_seen = 0;
        launch(8, 8, 16'h0300);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_data());
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rst_addr", sram_addr_o, '0);
        check("rst_done_pulses", done_seen, 0);
        launch(8, 8, 16'h0300);
        run_until_idle(70, 70, 200);
        check("after_rst_done", done_seen, 1);
        // random jobs with stray idle valids
        for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(3)) step(1'b0, 1'b0, $urandom_range(3) == 0, 1'b0, rnd_data());
            launch($urandom_range(40), $urandom_range(40), AW'($urandom));
            run_until_idle($urandom_range(20, 100), $urandom_range(20, 100), 3000);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
